// File: rtl/vedic_pkg.sv
// vedic_pkg: shared FSM state type, digit width and clog2 helper for the Vedic sequential multiplier
package vedic_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DIGIT_W = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/vedic_multiplier_2x2.sv
// vedic_multiplier_2x2: combinational 2x2 Vedic (Urdhva Tiryakbhyam) cell, p = a * b
module vedic_multiplier_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c;
  assign c = a[1] & b[0] & a[0] & b[1];
  assign p = {a[1] & b[1] & c, (a[1] & b[1]) ^ c, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
endmodule

// File: rtl/vedic_seq_mul_ctrl.sv
// vedic_seq_mul_ctrl: WIDTHxWIDTH product via one shared 2x2 Vedic cell, shift-add over digit pairs; VEDIC_ZERO_SKIP_EN bypasses zero operands
module vedic_seq_mul_ctrl
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N = WIDTH / DIGIT_W;
  localparam int KW = clog2(N * N);
  state_t state, state_nx;
  logic [KW-1:0] k, i, j;
  logic [WIDTH-1:0] ra, rb;
  logic [2*WIDTH-1:0] acc, pp_sh;
  logic [DIGIT_W-1:0] a_d, b_d;
  logic [3:0] pp;
  logic zero, last;
`ifdef VEDIC_ZERO_SKIP_EN
  assign zero = (a == '0) || (b == '0);
`else
  assign zero = 1'b0;
`endif
  assign i = k / KW'(N);
  assign j = k % KW'(N);
  assign a_d = DIGIT_W'(ra >> (DIGIT_W * i));
  assign b_d = DIGIT_W'(rb >> (DIGIT_W * j));
  assign last = k == KW'(N * N - 1);
  vedic_multiplier_2x2 u_cell (.a(a_d), .b(b_d), .p(pp));
  assign pp_sh = (2*WIDTH)'(pp) << (DIGIT_W * (i + j));
  assign in_ready = state == IDLE;
  assign busy = state == BUSY;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = zero ? DONE : BUSY;
    else if (state == BUSY && last) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= b;
        acc <= '0;
        k <= '0;
        if (zero) product <= '0;
      end
      if (state == BUSY) begin
        acc <= acc + pp_sh;
        k <= k + 1'b1;
        if (last) product <= acc + pp_sh;
      end
    end
  end
endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// tb_vedic_seq_mul_ctrl: scoreboard bench for vedic_seq_mul_ctrl with directed vectors
module tb_vedic_seq_mul_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [15:0] product;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int hs_cyc = -10;
  int acc_cyc = 0;
  logic [15:0] exp_q[$];
  vedic_seq_mul_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_cyc = cyc + 1;
      if (exp_q.size() == 0) check("unexpected_output", product, 16'hxxxx);
      else check("product", product, exp_q.pop_front());
    end
  end
  task automatic issue(input logic [7:0] va, input logic [7:0] vb);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 0, 1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hxx;
    b = 8'hxx;
  endtask
  task automatic run(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp,
                     input int lat, output int nb);
    int n;
    exp_q.push_back(exp);
    issue(va, vb);
    n = 0;
    nb = 0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      n++;
      @(negedge clk);
    end
    check("latency", n, lat);
  endtask
  initial begin
    int nb;
    int zlat;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nb;
    int zlat;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", {in_ready, out_valid, busy}, 3'b100);
    check("post_rst_product", product, 0);
    run(8'd13, 8'd11, 16'd143, 16, nb);
    check("busy_cycles", nb, 16);
    run(8'd255, 8'd255, 16'd65025, 16, nb);
    run(8'd170, 8'd85, 16'd14450, 16, nb);
    check("back_to_back_accept", acc_cyc, hs_cyc + 1);
`ifdef VEDIC_ZERO_SKIP_EN
    zlat = 0;
`else
    zlat = 16;
`endif
    run(8'd0, 8'd200, 16'd0, zlat, nb);
    check("zero_busy_cycles", nb, zlat);
    @(negedge clk);
    out_ready = 1'b0;
    run(8'd7, 8'd9, 16'd63, 16, nb);
    for (int c = 0; c < 5; c++) begin
      a = 8'd1;
      b = 8'd2;
      in_valid = c[0];
      check("bp_hold", {out_valid, in_ready, busy, product}, {3'b100, 16'd63});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {in_ready, out_valid}, 2'b10);
    issue(8'd200, 8'd3);
    repeat (6) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {in_ready, out_valid, busy}, 3'b100);
    check("mid_rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(8'd3, 8'd3, 16'd9, 16, nb);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_idle", in_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
